reg_file_scoreboard: RTL and testbench

- Register-file stage directly downstream of the decode-side register-read select logic.
- Consumes read-enable, two source addresses and destination info from decode, and holds the 32-entry integer register file.
- Tracks pending writes with a per-register busy scoreboard and stalls decode on RAW/WAW hazards.
- Presents registered operands to execute over a valid/ready handshake, and accepts writeback from the last stage.

---
 rtl/reg_file_scoreboard.sv | 126 ++++++++++++
 tb/tb_reg_file_scoreboard.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_scoreboard.sv
// Register-file stage: 32 x XLEN integer register file with a per-register
// busy scoreboard. It stalls decode on RAW/WAW hazards, registers operands
// toward execute over valid/ready, and accepts writeback from the last stage.
module reg_file_scoreboard #(
    parameter int XLEN   = 64,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic            ren,
    input  logic [4:0]      raddr1,
    input  logic [4:0]      raddr2,
    input  logic            rd_wen,
    input  logic [4:0]      rd,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_rdata1,
    output logic [XLEN-1:0] ex_rdata2,
    output logic [4:0]      ex_rd,
    output logic            ex_rd_wen,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic [31:0]     busy_vec
);

    localparam logic BYP = (BYPASS != 0);

    logic [XLEN-1:0] regs [32];
    logic [31:0]     busy;
    logic [31:0]     busy_nxt;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic            wb_hit;
    logic            fwd1;
    logic            fwd2;
    logic            fwdd;
    logic            sbusy1;
    logic            sbusy2;
    logic            sbusyd;
    logic            rd_live;
    logic            hazard;
    logic            issue;

    // x0 writeback is dropped entirely
    assign wb_hit  = wb_en && (wb_addr != 5'd0);
    assign rd_live = rd_wen && (rd != 5'd0);

    // A same-cycle writeback to a busy source resolves the hazard only when
    // forwarding is enabled; otherwise the stall lasts until the busy bit clears.
    assign fwd1   = BYP && wb_hit && (wb_addr == raddr1);
    assign fwd2   = BYP && wb_hit && (wb_addr == raddr2);
    assign fwdd   = BYP && wb_hit && (wb_addr == rd);
    assign sbusy1 = busy[raddr1] && !fwd1;
    assign sbusy2 = busy[raddr2] && !fwd2;
    assign sbusyd = busy[rd] && !fwdd;

    // Both sources are checked whenever ren is set, even for one-source ops
    assign hazard   = (ren && (sbusy1 || sbusy2)) || (rd_live && sbusyd);
    assign id_ready = !hazard && !flush && (!ex_valid || ex_ready);
    assign issue    = id_valid && id_ready;
    assign busy_vec = busy;

    // Operand read with optional writeback forwarding; x0 and ren=0 read zero
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (ren && (raddr1 != 5'd0))
            rdata1 = fwd1 ? wb_data : regs[raddr1];
        if (ren && (raddr2 != 5'd0))
            rdata2 = fwd2 ? wb_data : regs[raddr2];
    end

    // Scoreboard next state: writeback and flush clear, issue sets last so it wins
    always_comb begin
        busy_nxt = busy;
        if (wb_hit)
            busy_nxt[wb_addr] = 1'b0;
        if (flush && ex_valid && ex_rd_wen)
            busy_nxt[ex_rd] = 1'b0;
        if (issue && rd_live)
            busy_nxt[rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // Register file array and writeback port
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= '0;
        end else if (wb_hit) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Busy scoreboard register
    always_ff @(posedge clk) begin
        if (rst)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

    // Operand register toward execute; payload holds when nothing issues
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid  <= 1'b0;
            ex_rdata1 <= '0;
            ex_rdata2 <= '0;
            ex_rd     <= 5'd0;
            ex_rd_wen <= 1'b0;
        end else if (issue) begin
            ex_valid  <= 1'b1;
            ex_rdata1 <= rdata1;
            ex_rdata2 <= rdata2;
            ex_rd     <= rd;
            ex_rd_wen <= rd_live;
        end else if (ex_ready || flush) begin
            ex_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Bench for reg_file_scoreboard: a BYPASS=1 and a BYPASS=0 instance share the
// same stimulus; each is compared every cycle against an array-based model,
// with directed literal checks followed by a randomized phase.
module tb_reg_file_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic        ren;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic        rd_wen;
    logic [4:0]  rd;
    logic        ex_ready;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [63:0] wb_data;
    logic        flush;

    logic [1:0]        rdy;
    logic [1:0]        exv;
    logic [1:0]        exwen;
    logic [1:0][4:0]   exrd;
    logic [1:0][63:0]  ex1;
    logic [1:0][63:0]  ex2;
    logic [1:0][31:0]  bvec;

    int n_chk  = 0;
    int n_pass = 0;
    bit armed  = 1'b0;

    always #5 clk = ~clk;

    reg_file_scoreboard #(.XLEN(64), .BYPASS(0)) u0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(rdy[0]),
        .ren(ren), .raddr1(raddr1), .raddr2(raddr2), .rd_wen(rd_wen), .rd(rd),
        .ex_valid(exv[0]), .ex_ready(ex_ready), .ex_rdata1(ex1[0]), .ex_rdata2(ex2[0]),
        .ex_rd(exrd[0]), .ex_rd_wen(exwen[0]), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .flush(flush), .busy_vec(bvec[0])
    );

    reg_file_scoreboard #(.XLEN(64), .BYPASS(1)) u1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(rdy[1]),
        .ren(ren), .raddr1(raddr1), .raddr2(raddr2), .rd_wen(rd_wen), .rd(rd),
        .ex_valid(exv[1]), .ex_ready(ex_ready), .ex_rdata1(ex1[1]), .ex_rdata2(ex2[1]),
        .ex_rd(exrd[1]), .ex_rd_wen(exwen[1]), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .flush(flush), .busy_vec(bvec[1])
    );

    // ---------------- behavioural model (index b = BYPASS value) ----------
    logic [63:0] mregs [2][32];
    logic [31:0] mbusy [2];
    logic [1:0]  mexv;
    logic [1:0]  mexwen;
    logic [4:0]  mexrd [2];
    logic [63:0] mex1 [2];
    logic [63:0] mex2 [2];

    function automatic logic m_sbusy(int b, logic [4:0] a);
        return mbusy[b][a] && !(b == 1 && wb_en && wb_addr == a && a != 0);
    endfunction

    function automatic logic m_ready(int b);
        logic haz;
        haz = (ren && (m_sbusy(b, raddr1) || m_sbusy(b, raddr2))) ||
              (rd_wen && rd != 0 && m_sbusy(b, rd));
        return !haz && !flush && (!mexv[b] || ex_ready);
    endfunction

    function automatic logic [63:0] m_read(int b, logic [4:0] a);
        if (!ren || a == 0) return 64'd0;
        if (b == 1 && wb_en && wb_addr == a) return wb_data;
        return mregs[b][a];
    endfunction

    task automatic m_step(int b);
        logic        r;
        logic [63:0] d1, d2;
        logic [31:0] nb;
        if (rst) begin
            for (int i = 0; i < 32; i++) mregs[b][i] = 64'd0;
            mbusy[b] = 32'd0;
            mexv[b] = 1'b0; mexwen[b] = 1'b0; mexrd[b] = 5'd0;
            mex1[b] = 64'd0; mex2[b] = 64'd0;
            return;
        end
        r  = m_ready(b);
        d1 = m_read(b, raddr1);
        d2 = m_read(b, raddr2);
        nb = mbusy[b];
        if (wb_en && wb_addr != 0) begin
            mregs[b][wb_addr] = wb_data;
            nb[wb_addr] = 1'b0;
        end
        if (flush && mexv[b] && mexwen[b]) nb[mexrd[b]] = 1'b0;
        if (id_valid && r) begin
            mexv[b] = 1'b1; mex1[b] = d1; mex2[b] = d2; mexrd[b] = rd;
            mexwen[b] = rd_wen && rd != 0;
            if (rd_wen && rd != 0) nb[rd] = 1'b1;
        end else if (ex_ready || flush) begin
            mexv[b] = 1'b0;
        end
        mbusy[b] = nb;
    endtask

    task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    endtask

    // Model advances on the same edge the DUTs do
    initial forever begin
        @(posedge clk);
        for (int b = 0; b < 2; b++) m_step(b);
    end

    // Every-cycle comparison against the model, away from the active edge
    initial forever begin
        @(negedge clk);
        if (armed) begin
            for (int b = 0; b < 2; b++) begin
                chk($sformatf("d%0d id_ready", b),  {63'd0, rdy[b]},   {63'd0, m_ready(b)});
                chk($sformatf("d%0d ex_valid", b),  {63'd0, exv[b]},   {63'd0, mexv[b]});
                chk($sformatf("d%0d ex_rd_wen", b), {63'd0, exwen[b]}, {63'd0, mexwen[b]});
                chk($sformatf("d%0d ex_rd", b),     {59'd0, exrd[b]},  {59'd0, mexrd[b]});
                chk($sformatf("d%0d ex_rdata1", b), ex1[b], mex1[b]);
                chk($sformatf("d%0d ex_rdata2", b), ex2[b], mex2[b]);
                chk($sformatf("d%0d busy_vec", b),  {32'd0, bvec[b]},  {32'd0, mbusy[b]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; ren = 0; raddr1 = 0; raddr2 = 0; rd_wen = 0; rd = 0;
        ex_ready = 1; wb_en = 0; wb_addr = 0; wb_data = 0; flush = 0;
    endtask

    initial begin
        rst = 1; idle();
        tick(); tick();
        rst = 0; armed = 1'b1;
        #1;
        chk("reset ex_valid", {62'd0, exv}, 64'd0);
        chk("reset busy", {bvec[1], bvec[0]}, 64'd0);
        chk("reset id_ready", {62'd0, rdy}, 64'd3);
        chk("reset ex_rdata1", ex1[1], 64'd0);

        // basic write then read
        wb_en = 1; wb_addr = 5; wb_data = 64'h1234;
        tick();
        wb_en = 0; id_valid = 1; ren = 1; raddr1 = 5; raddr2 = 0;
        tick();
        chk("basic ex_valid", {62'd0, exv}, 64'd3);
        chk("basic rdata1 b1", ex1[1], 64'h1234);
        chk("basic rdata1 b0", ex1[0], 64'h1234);
        chk("basic rdata2", ex2[1], 64'd0);

        // RAW: writer of x7 then reader of x7
        ren = 0; rd_wen = 1; rd = 7;
        tick();
        chk("raw busy7", {62'd0, bvec[1][7], bvec[0][7]}, 64'd3);
        rd_wen = 0; ren = 1; raddr1 = 7; raddr2 = 0;
        #1 chk("raw stall", {62'd0, rdy}, 64'd0);
        tick();
        chk("raw stall held", {62'd0, rdy}, 64'd0);
        wb_en = 1; wb_addr = 7; wb_data = 64'hAA;
        #1 chk("raw wb-cycle ready", {62'd0, rdy}, 64'd2);
        tick();
        wb_en = 0;
        chk("raw bypass data", ex1[1], 64'hAA);
        #1 chk("raw nobypass ready", {63'd0, rdy[0]}, 64'd1);
        tick();
        chk("raw nobypass data", ex1[0], 64'hAA);
        chk("raw nobypass valid", {63'd0, exv[0]}, 64'd1);

        // WAW on x3
        ren = 0; rd_wen = 1; rd = 3;
        tick();
        #1 chk("waw stall", {62'd0, rdy}, 64'd0);
        wb_en = 1; wb_addr = 3; wb_data = 64'h33;
        tick();
        wb_en = 0;
        chk("waw set wins", {63'd0, bvec[1][3]}, 64'd1);
        tick();
        id_valid = 0; wb_en = 1; wb_addr = 3;
        tick();
        wb_en = 0;
        chk("waw cleared", {bvec[1], bvec[0]}, 64'd0);

        // x0 never becomes busy nor writable
        id_valid = 1; rd_wen = 1; rd = 0;
        tick();
        chk("x0 busy", {bvec[1], bvec[0]}, 64'd0);
        chk("x0 ex_rd_wen", {62'd0, exwen}, 64'd0);
        rd_wen = 0; wb_en = 1; wb_addr = 0; wb_data = 64'hFF; ren = 1; raddr1 = 0;
        tick();
        wb_en = 0;
        tick();
        chk("x0 read", ex1[1] | ex1[0], 64'd0);

        // back-pressure
        raddr1 = 5;
        tick();
        raddr1 = 7; ex_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp ready", {62'd0, rdy}, 64'd0);
            tick();
            chk("bp hold", ex1[1], 64'h1234);
        end
        ex_ready = 1;
        #1 chk("bp release ready", {62'd0, rdy}, 64'd3);
        tick();
        chk("bp next issue", ex1[1], 64'hAA);

        // flush kills x9 writer and its busy bit
        ren = 0; rd_wen = 1; rd = 9;
        tick();
        rd_wen = 0; ren = 1; raddr1 = 5; flush = 1;
        #1 chk("flush ready", {62'd0, rdy}, 64'd0);
        tick();
        flush = 0;
        chk("flush valid", {62'd0, exv}, 64'd0);
        chk("flush busy9", {62'd0, bvec[1][9], bvec[0][9]}, 64'd0);
        tick();
        chk("flush reissue", {62'd0, exv}, 64'd3);
        chk("flush reissue data", ex1[1], 64'h1234);

        // randomized phase
        for (int c = 0; c < 3000; c++) begin
            rst      = ($urandom_range(0, 199) == 0);
            id_valid = ($urandom_range(0, 9) < 7);
            ren      = ($urandom_range(0, 9) < 7);
            raddr1   = 5'($urandom_range(0, 7));
            raddr2   = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            rd_wen   = ($urandom_range(0, 9) < 6);
            rd       = 5'($urandom_range(0, 7));
            wb_en    = ($urandom_range(0, 9) < 4);
            wb_addr  = 5'($urandom_range(0, 7));
            wb_data  = {$urandom, $urandom};
            ex_ready = ($urandom_range(0, 9) < 7);
            flush    = ($urandom_range(0, 19) == 0);
            tick();
        end
        rst = 0; idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
